// File: rtl/trace_link_h2t_bytes_to_packets_if.sv
// trace_link_h2t_bytes_to_packets_if: encoded byte stream in, decoded packet stream out
interface trace_link_h2t_bytes_to_packets_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [7:0]               out_data;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic [CHANNEL_WIDTH-1:0] out_channel;
    logic                     out_ready;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
    );
endinterface

// File: rtl/trace_link_h2t_bytes_to_packets.sv
// trace_link_h2t_bytes_to_packets: strips SOP/EOP/channel/escape framing from a byte stream
module trace_link_h2t_bytes_to_packets #(
    parameter int CHANNEL_WIDTH = 8
) (
    input logic clk,
    input logic reset,
    trace_link_h2t_bytes_to_packets_if.slave bus
);
    typedef enum logic [1:0] {DATA, ESC, CHAN, CHAN_ESC} state_t;
    state_t                   state_q, state_d;
    logic                     sop_q, sop_d, eop_q, eop_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic                     ov_q, ov_d, os_q, os_d, oe_q, oe_d;
    logic [7:0]               od_q, od_d;
    logic [CHANNEL_WIDTH-1:0] oc_q, oc_d;
    logic                     accept, is_data;
    logic [7:0]               dbyte, unesc;
    assign bus.in_ready          = !ov_q || bus.out_ready;
    assign accept                = bus.in_valid && bus.in_ready;
    assign unesc                 = bus.in_data ^ 8'h20;
    assign bus.out_valid         = ov_q;
    assign bus.out_data          = od_q;
    assign bus.out_startofpacket = os_q;
    assign bus.out_endofpacket   = oe_q;
    assign bus.out_channel       = oc_q;
    // decode the accepted byte and load or drain the output register
    always_comb begin
        state_d = state_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        chan_d  = chan_q;
        ov_d    = ov_q;
        od_d    = od_q;
        os_d    = os_q;
        oe_d    = oe_q;
        oc_d    = oc_q;
        is_data = 1'b0;
        dbyte   = bus.in_data;
        if (accept) begin
            case (state_q)
                DATA: begin
                    if (bus.in_data == 8'h7A) sop_d = 1'b1;
                    else if (bus.in_data == 8'h7B) eop_d = 1'b1;
                    else if (bus.in_data == 8'h7C) state_d = CHAN;
                    else if (bus.in_data == 8'h7D) state_d = ESC;
                    else is_data = 1'b1;
                end
                ESC: begin
                    is_data = 1'b1;
                    dbyte   = unesc;
                    state_d = DATA;
                end
                CHAN: begin
                    if (bus.in_data == 8'h7D) state_d = CHAN_ESC;
                    else begin
                        chan_d  = bus.in_data[CHANNEL_WIDTH-1:0];
                        state_d = DATA;
                    end
                end
                default: begin
                    chan_d  = unesc[CHANNEL_WIDTH-1:0];
                    state_d = DATA;
                end
            endcase
        end
        if (is_data) begin
            ov_d  = 1'b1;
            od_d  = dbyte;
            os_d  = sop_q;
            oe_d  = eop_q;
            oc_d  = chan_q;
            sop_d = 1'b0;
            eop_d = 1'b0;
        end else if (bus.out_ready) begin
            ov_d = 1'b0;
        end
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DATA;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            chan_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            os_q    <= 1'b0;
            oe_q    <= 1'b0;
            oc_q    <= '0;
        end else begin
            state_q <= state_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            chan_q  <= chan_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            os_q    <= os_d;
            oe_q    <= oe_d;
            oc_q    <= oc_d;
        end
    end
endmodule

// File: tb/tb_trace_link_h2t_bytes_to_packets.sv
// tb_trace_link_h2t_bytes_to_packets: directed checks of the byte-to-packet decoder
module tb_trace_link_h2t_bytes_to_packets;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    trace_link_h2t_bytes_to_packets_if #(.CHANNEL_WIDTH(8)) b8 ();
    trace_link_h2t_bytes_to_packets_if #(.CHANNEL_WIDTH(2)) b2 ();
    trace_link_h2t_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    trace_link_h2t_bytes_to_packets #(.CHANNEL_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] d, input logic rdy);
        b8.in_valid  = 1'b1;
        b8.in_data   = d;
        b8.out_ready = rdy;
        cyc();
        b8.in_valid = 1'b0;
    endtask
    task automatic send2(input logic [7:0] d);
        b2.in_valid = 1'b1;
        b2.in_data  = d;
        cyc();
        b2.in_valid = 1'b0;
    endtask
    task automatic beat(input string tag, input logic [7:0] d, input logic s, input logic e, input logic [7:0] ch);
        chk({tag, ".valid"}, {7'd0, b8.out_valid}, 8'd1);
        chk({tag, ".data"}, b8.out_data, d);
        chk({tag, ".sop"}, {7'd0, b8.out_startofpacket}, {7'd0, s});
        chk({tag, ".eop"}, {7'd0, b8.out_endofpacket}, {7'd0, e});
        chk({tag, ".ch"}, b8.out_channel, ch);
    endtask
    task automatic none(input string tag);
        chk({tag, ".novalid"}, {7'd0, b8.out_valid}, 8'd0);
    endtask
    initial begin
        b8.in_valid = 1'b0; b8.in_data = 8'h00; b8.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_data = 8'h00; b2.out_ready = 1'b1;
        cyc(); cyc();
        chk("rst.valid", {7'd0, b8.out_valid}, 8'd0);
        chk("rst.data", b8.out_data, 8'h00);
        chk("rst.sop", {7'd0, b8.out_startofpacket}, 8'd0);
        chk("rst.eop", {7'd0, b8.out_endofpacket}, 8'd0);
        chk("rst.ch", b8.out_channel, 8'h00);
        reset = 1'b0;
        chk("rst.in_ready", {7'd0, b8.in_ready}, 8'd1);
        send(8'h7A, 1'b1); none("t1.7A");
        send(8'h7C, 1'b1); none("t1.7C");
        send(8'h03, 1'b1); none("t1.03");
        send(8'h11, 1'b1); beat("t1.b11", 8'h11, 1'b1, 1'b0, 8'h03);
        send(8'h22, 1'b1); beat("t1.b22", 8'h22, 1'b0, 1'b0, 8'h03);
        send(8'h7B, 1'b1); none("t1.7B");
        send(8'h33, 1'b1); beat("t1.b33", 8'h33, 1'b0, 1'b1, 8'h03);
        cyc(); none("t1.idle");
        send(8'h7A, 1'b1);
        send(8'h7D, 1'b1); none("t2.esc1");
        send(8'h5A, 1'b1); beat("t2.b7A", 8'h7A, 1'b1, 1'b0, 8'h03);
        send(8'h7D, 1'b1); none("t2.esc2");
        send(8'h5D, 1'b1); beat("t2.b7D", 8'h7D, 1'b0, 1'b0, 8'h03);
        send(8'h7B, 1'b1);
        send(8'h7D, 1'b1); none("t2.esc3");
        send(8'h5B, 1'b1); beat("t2.b7B", 8'h7B, 1'b0, 1'b1, 8'h03);
        send(8'h7C, 1'b1);
        send(8'h7D, 1'b1);
        send(8'h5C, 1'b1);
        send(8'h7A, 1'b1);
        send(8'h7B, 1'b1); none("t3.ctl");
        send(8'h44, 1'b1); beat("t3.b44", 8'h44, 1'b1, 1'b1, 8'h7C);
        send(8'h01, 1'b1); beat("t4.b01", 8'h01, 1'b0, 1'b0, 8'h7C);
        b8.in_valid = 1'b1; b8.in_data = 8'h02; b8.out_ready = 1'b0;
        #1 chk("t4.in_ready0", {7'd0, b8.in_ready}, 8'd0);
        cyc(); beat("t4.hold1", 8'h01, 1'b0, 1'b0, 8'h7C);
        cyc(); beat("t4.hold2", 8'h01, 1'b0, 1'b0, 8'h7C);
        chk("t4.in_ready1", {7'd0, b8.in_ready}, 8'd0);
        b8.out_ready = 1'b1;
        #1 chk("t4.in_ready2", {7'd0, b8.in_ready}, 8'd1);
        cyc(); b8.in_valid = 1'b0;
        beat("t4.b02", 8'h02, 1'b0, 1'b0, 8'h7C);
        cyc(); none("t4.drain");
        send(8'h7A, 1'b1);
        send(8'h7D, 1'b1);
        reset = 1'b1;
        cyc();
        chk("t5.valid", {7'd0, b8.out_valid}, 8'd0);
        chk("t5.data", b8.out_data, 8'h00);
        chk("t5.sop", {7'd0, b8.out_startofpacket}, 8'd0);
        chk("t5.eop", {7'd0, b8.out_endofpacket}, 8'd0);
        chk("t5.ch", b8.out_channel, 8'h00);
        reset = 1'b0;
        b8.in_valid = 1'b1; b8.in_data = 8'h41;
        #1 chk("t5.in_ready", {7'd0, b8.in_ready}, 8'd1);
        cyc(); b8.in_valid = 1'b0;
        beat("t5.b41", 8'h41, 1'b0, 1'b0, 8'h00);
        send2(8'h7C);
        send2(8'h05);
        send2(8'hAA);
        chk("t6.aa.valid", {7'd0, b2.out_valid}, 8'd1);
        chk("t6.aa.data", b2.out_data, 8'hAA);
        chk("t6.aa.sop", {7'd0, b2.out_startofpacket}, 8'd0);
        chk("t6.aa.ch", {6'd0, b2.out_channel}, 8'h01);
        send2(8'h7A);
        chk("t6.7A.novalid", {7'd0, b2.out_valid}, 8'd0);
        send2(8'hBB);
        chk("t6.bb.valid", {7'd0, b2.out_valid}, 8'd1);
        chk("t6.bb.data", b2.out_data, 8'hBB);
        chk("t6.bb.sop", {7'd0, b2.out_startofpacket}, 8'd1);
        chk("t6.bb.ch", {6'd0, b2.out_channel}, 8'h01);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
